// File: rtl/alu_share_if.sv
// Request/response bundle between the requesters and the shared ALU arbiter.
// The master side drives requests and consumes responses; the arbiter is the slave.
interface alu_share_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_y;
  logic                  resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y, resp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-shared 32-bit ALU: one op in flight, result held until consumed.
// Define ALU_ARB_DIV_EN to build the iterative restoring divider for div/mod.
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_share_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;

`ifdef ALU_ARB_DIV_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_y_q, resp_y_d;
  logic             resp_err_q, resp_err_d;

  logic             gnt_found, accept;
  logic [IDW-1:0]   gnt_idx, cand;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   exec_res;

`ifdef ALU_ARB_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d, dq_q, dq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign div_shift = {rem_q, dq_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
`endif

  // Single-cycle ops; returns {err, y}. div/mod only reach here with B == 0.
  function automatic logic [WIDTH:0] alu_exec(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    logic             err;
    y   = '0;
    err = 1'b0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MUL: y = a * b;
`ifdef ALU_ARB_DIV_EN
      OP_DIV: y = '1;
      OP_MOD: y = a;
`else
      OP_DIV: err = 1'b1;
      OP_MOD: err = 1'b1;
`endif
      OP_XOR: y = a ^ b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_SHR: y = (b >= WIDTH'(WIDTH)) ? '0 : (a >> b);
      OP_SHL: y = (b >= WIDTH'(WIDTH)) ? '0 : (a << b);
      default: err = 1'b1;
    endcase
    return {err, y};
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept        = (state_q == IDLE) && gnt_found && !rst;
  assign bus.req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign op_sel        = bus.req_op[4*gnt_idx +: 4];
  assign a_sel         = bus.req_a[WIDTH*gnt_idx +: WIDTH];
  assign b_sel         = bus.req_b[WIDTH*gnt_idx +: WIDTH];
  assign exec_res      = alu_exec(op_q, a_q, b_q);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_y_d     = resp_y_q;
    resp_err_d   = resp_err_q;
`ifdef ALU_ARB_DIV_EN
    rem_d = rem_q;
    dq_d  = dq_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d     = gnt_idx;
          op_d     = op_sel;
          a_d      = a_sel;
          b_d      = b_sel;
          rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = EXEC;
`ifdef ALU_ARB_DIV_EN
          if ((op_sel == OP_DIV || op_sel == OP_MOD) && b_sel != '0) begin
            state_d = DIV;
            rem_d   = '0;
            dq_d    = a_sel;
            cnt_d   = '0;
          end
`endif
        end
      end
      EXEC: begin
        resp_err_d   = exec_res[WIDTH];
        resp_y_d     = exec_res[WIDTH-1:0];
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
`ifdef ALU_ARB_DIV_EN
      DIV: begin
        rem_d = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
        dq_d  = {dq_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          resp_y_d     = (op_q == OP_DIV) ? dq_d : rem_d;
          resp_err_d   = 1'b0;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
`endif
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    id_q <= id_d;
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
`ifdef ALU_ARB_DIV_EN
    rem_q <= rem_d;
    dq_q  <= dq_d;
    cnt_q <= cnt_d;
`endif
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_y_q     <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_y_q     <= resp_y_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_y     = resp_y_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: accepts push expected responses, a monitor pops and compares.
// Expected values come from a plain-arithmetic ALU model and a round-robin pointer model.
module tb_alu_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();
  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          id;
    logic [31:0] y;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   acc_order[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic [NREQ-1:0] acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU: {err, y}
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a * b};
`ifdef ALU_ARB_DIV_EN
      4'd3: return (b == 0) ? {1'b0, 32'hFFFF_FFFF} : {1'b0, a / b};
      4'd4: return (b == 0) ? {1'b0, a} : {1'b0, a % b};
`else
      4'd3: return {1'b1, 32'h0};
      4'd4: return {1'b1, 32'h0};
`endif
      4'd5: return {1'b0, a ^ b};
      4'd6: return {1'b0, a & b};
      4'd7: return {1'b0, a | b};
      4'd8: return (b >= 32) ? {1'b0, 32'h0} : {1'b0, a >> b};
      4'd9: return (b >= 32) ? {1'b0, 32'h0} : {1'b0, a << b};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_ARB_DIV_EN
    if ((op == 4'd3 || op == 4'd4) && b != 0) return WIDTH + 1;
`endif
    return 2;
  endfunction

  // Accept monitor: checks the grant against a round-robin model and pushes the expected response.
  int          mptr = 0;
  int          m_exp, m_got;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [32:0] m_r;
  exp_t        m_e;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mptr = 0;
    end else if (bus.req_ready != '0) begin
      m_exp = -1;
      for (int k = 0; k < NREQ; k++)
        if (m_exp < 0 && bus.req_valid[(mptr + k) % NREQ]) m_exp = (mptr + k) % NREQ;
      chk("grant", 64'(bus.req_ready), (m_exp < 0) ? 64'h0 : (64'h1 << m_exp));
      m_got = -1;
      for (int k = NREQ - 1; k >= 0; k--)
        if (bus.req_ready[k] && bus.req_valid[k]) m_got = k;
      if (m_got >= 0) begin
        m_op  = bus.req_op[4*m_got +: 4];
        m_a   = bus.req_a[32*m_got +: 32];
        m_b   = bus.req_b[32*m_got +: 32];
        m_r   = model(m_op, m_a, m_b);
        m_e.id  = m_got;
        m_e.y   = m_r[31:0];
        m_e.err = m_r[32];
        m_e.due = cyc + latency(m_op, m_b);
        sb.push_back(m_e);
        mptr = (m_got + 1) % NREQ;
      end
    end
  end

  // Response monitor: latency on first presentation, stability while held, data at handshake.
  logic        prev_v = 1'b0;
  logic [31:0] prev_y;
  logic [1:0]  prev_id;
  logic        prev_err;
  exp_t        r_e;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      prev_v = 1'b0;
    end else begin
      if (bus.resp_valid) begin
        if (!prev_v) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got id %0d y 0x%0h, required no response", bus.resp_id, bus.resp_y);
          end else begin
            chk("resp_latency", 64'(cyc), 64'(sb[0].due));
          end
        end else begin
          chk("hold_y", 64'(bus.resp_y), 64'(prev_y));
          chk("hold_id_err", {62'h0, bus.resp_id}, {62'h0, prev_id});
          chk("hold_err", 64'(bus.resp_err), 64'(prev_err));
        end
        chk("ready_in_resp", 64'(bus.req_ready), 64'h0);
        if (bus.resp_ready && sb.size() > 0) begin
          r_e = sb.pop_front();
          chk("resp_id", 64'(bus.resp_id), 64'(r_e.id));
          chk("resp_y", 64'(bus.resp_y), 64'(r_e.y));
          chk("resp_err", 64'(bus.resp_err), 64'(r_e.err));
        end
        prev_y   = bus.resp_y;
        prev_id  = bus.resp_id;
        prev_err = bus.resp_err;
      end
      prev_v = bus.resp_valid;
    end
  end

  task automatic step();
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) begin
        bus.req_valid[i] = 1'b0;
        acc_order.push_back(i);
      end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_op[4*i +: 4]   = op;
    bus.req_a[32*i +: 32]  = a;
    bus.req_b[32*i +: 32]  = b;
  endtask

  task automatic wait_idle_all(input int limit, input string name);
    int n;
    n = 0;
    do begin
      step();
      clear_acc();
      n++;
    end while (!(bus.req_valid == '0 && sb.size() == 0 && !bus.resp_valid) && n < limit);
    if (n >= limit) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  function automatic logic [63:0] pack_order();
    logic [63:0] v;
    v = 64'(acc_order.size()) << 32;
    foreach (acc_order[k]) v[31:0] = (v[31:0] << 4) | 32'(acc_order[k]);
    return v;
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } dir_t;

  dir_t dir[$];
  int   issued;
  int   nloop;

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    step();
    step();

    // All four requesters valid out of reset: expect accept order 0,1,2,3.
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i), $urandom, $urandom_range(0, 40));
    @(negedge clk);
    chk("ready_in_reset", 64'(bus.req_ready), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'h0);
    chk("rst_resp_y", 64'(bus.resp_y), 64'h0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'h0);
    chk("first_grant", 64'(bus.req_ready), 64'h1);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    acc_order.delete();
    clear_acc();
    wait_idle_all(200, "rr4");
    chk("rr_order_0123", pack_order(), {32'd4, 32'h0123});

    acc_order.delete();
    set_req(0, 4'd0, 32'd1, 32'd2);
    set_req(2, 4'd7, 32'hF0, 32'h0F);
    wait_idle_all(200, "rr2");
    chk("rr_order_02", pack_order(), {32'd2, 32'h02});

    // Directed ops on requester 0 with resp_ready high.
    dir.push_back('{4'd0, 32'd7, 32'd5});
    dir.push_back('{4'd1, 32'd5, 32'd7});
    dir.push_back('{4'd2, 32'h10000, 32'h10000});
    dir.push_back('{4'd9, 32'd1, 32'd32});
    dir.push_back('{4'd8, 32'h8000_0000, 32'd31});
    dir.push_back('{4'd3, 32'd100, 32'd7});
    dir.push_back('{4'd4, 32'd100, 32'd7});
    dir.push_back('{4'd3, 32'd9, 32'd0});
    dir.push_back('{4'd4, 32'd9, 32'd0});
    dir.push_back('{4'd12, 32'd3, 32'd4});
    dir.push_back('{4'd3, 32'hFFFF_FFFF, 32'd1});
    dir.push_back('{4'd4, 32'hDEAD_BEEF, 32'h0001_0000});
    dir.push_back('{4'd5, 32'hA5A5_A5A5, 32'hFFFF_0000});
    dir.push_back('{4'd6, 32'hA5A5_A5A5, 32'h0F0F_0F0F});
    dir.push_back('{4'd9, 32'h0000_0003, 32'd31});
    dir.push_back('{4'd15, 32'd1, 32'd1});
    foreach (dir[k]) begin
      set_req(0, dir[k].op, dir[k].a, dir[k].b);
      wait_idle_all(100, "directed");
    end

    // Backpressure: hold RESP for 10 cycles while another requester waits.
    bus.resp_ready = 1'b0;
    set_req(1, 4'd0, 32'd3, 32'd4);
    nloop = 0;
    do begin
      step();
      clear_acc();
      nloop++;
    end while (!bus.resp_valid && nloop < 50);
    chk("bp_resp_valid", 64'(bus.resp_valid), 64'h1);
    set_req(2, 4'd1, 32'd10, 32'd3);
    repeat (10) step();
    chk("bp_still_valid", 64'(bus.resp_valid), 64'h1);
    bus.resp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_idle_after", 64'(bus.resp_valid), 64'h0);
    chk("bp_next_grant", 64'(bus.req_ready), 64'h4);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    clear_acc();
    wait_idle_all(100, "bp");

    // Reset while a div from requester 2 is in flight; the op must vanish.
`ifndef ALU_ARB_DIV_EN
    bus.resp_ready = 1'b0;
`endif
    set_req(2, 4'd3, 32'd100, 32'd7);
    nloop = 0;
    do begin
      step();
      nloop++;
    end while (acc[2] == 1'b0 && nloop < 50);
    clear_acc();
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    set_req(3, 4'd0, 32'd30, 32'd3);
    set_req(0, 4'd0, 32'd40, 32'd4);
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.resp_valid), 64'h0);
    chk("mid_rst_id", 64'(bus.resp_id), 64'h0);
    chk("mid_rst_y", 64'(bus.resp_y), 64'h0);
    chk("mid_rst_err", 64'(bus.resp_err), 64'h0);
    chk("mid_rst_grant0", 64'(bus.req_ready), 64'h1);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    clear_acc();
    wait_idle_all(100, "post_rst");

    // Randomized traffic with random backpressure.
    issued = 0;
    nloop  = 0;
    while ((issued < 150 || bus.req_valid != '0) && nloop < 20000) begin
      step();
      nloop++;
      clear_acc();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && issued < 150 && $urandom_range(0, 2) == 0) begin
          logic [3:0]  rop;
          logic [31:0] rb;
          rop = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
          case ($urandom_range(0, 3))
            0:       rb = 32'h0;
            1:       rb = $urandom_range(0, 40);
            2:       rb = $urandom_range(1, 255);
            default: rb = $urandom;
          endcase
          set_req(i, rop, $urandom, rb);
          issued++;
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
    if (nloop >= 20000) begin
      tests++;
      fails++;
      $display("FAIL timeout_random: issued %0d in %0d cycles, required 150 accepted", issued, nloop);
    end
    bus.resp_ready = 1'b1;
    wait_idle_all(200, "drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
